// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer slice.
//   db_state_e        : per-channel debounce FSM encoding (bit 1 is the debounced level)
//   DB_CYCLES_DEFAULT : hold window in clock cycles (10 ms at 100 MHz)
//   SYNC_STAGES_DEFAULT : synchroniser depth
//   cnt_width()       : hold-counter width for a given window, never below 1 bit
package debounce_pkg;

  // Bit 1 of the encoding equals the debounced output level, so the
  // output can be taken straight from the state register.
  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_WAIT_HI   = 2'b01,
    ST_STABLE_HI = 2'b11,
    ST_WAIT_LO   = 2'b10
  } db_state_e;

  localparam int unsigned DB_CYCLES_DEFAULT   = 32'd1000000;
  localparam int unsigned SYNC_STAGES_DEFAULT = 32'd2;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles > 32'd1) begin
      return $clog2(cycles);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: SYNC_STAGES-flop synchroniser, 4-state debounce FSM
// and hold counter.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   sw    : raw asynchronous switch input
//   out   : debounced level, registered
//   upd   : one-cycle pulse on the edge where out toggles
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic out,
  output logic upd
);

  localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'd1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  db_state_e              state_r;
  db_state_e              state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;
  logic                   upd_r;
  logic                   upd_s;

  // Synchroniser shift chain; the FSM only ever sees the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sw};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // FSM state, hold counter and update-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_STABLE_LO;
      cnt_r   <= '0;
      upd_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      upd_r   <= upd_s;
    end
  end

  // Next-state logic: a WAIT state needs DB_CYCLES further agreeing samples
  // after entry; any disagreement falls back to the stable state and the
  // window restarts from zero on the next attempt.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    upd_s   = 1'b0;
    case (state_r)
      ST_STABLE_LO: begin
        if (sync_s) begin
          state_s = ST_WAIT_HI;
          cnt_s   = '0;
        end else begin
          state_s = ST_STABLE_LO;
        end
      end
      ST_WAIT_HI: begin
        if (!sync_s) begin
          state_s = ST_STABLE_LO;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_STABLE_HI;
          cnt_s   = '0;
          upd_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_STABLE_HI: begin
        if (!sync_s) begin
          state_s = ST_WAIT_LO;
          cnt_s   = '0;
        end else begin
          state_s = ST_STABLE_HI;
        end
      end
      ST_WAIT_LO: begin
        if (sync_s) begin
          state_s = ST_STABLE_HI;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_STABLE_LO;
          cnt_s   = '0;
          upd_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = ST_STABLE_LO;
        cnt_s   = '0;
      end
    endcase
  end

  // The level is bit 1 of the registered state (1 in STABLE_HI and WAIT_LO).
  assign out = state_r[1];
  assign upd = upd_r;

endmodule

// File: rtl/switch_debounce3.sv
// Three-channel synchroniser/debouncer producing the clean a/b/c operands for
// the downstream x = (a ^ b) | c logic.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   sw_in : raw switch inputs, [0]->a, [1]->b, [2]->c
//   a,b,c : debounced levels, registered
//   upd   : per-channel one-cycle pulse when that channel's level toggles
module switch_debounce3
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] upd
);

  logic [2:0] level_s;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .sw   (sw_in[i]),
      .out  (level_s[i]),
      .upd  (upd[i])
    );
  end

  assign a = level_s[0];
  assign b = level_s[1];
  assign c = level_s[2];

endmodule

// File: tb/tb_switch_debounce3.sv
// Randomised/directed bench for switch_debounce3 (DB_CYCLES=4, SYNC_STAGES=2).
// A run-length reference model pushes the expected {level, upd} per edge into
// a queue; a monitor on the falling edge pops and compares.
module tb_switch_debounce3;

  localparam int DB   = 4;
  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_in;
  logic       a, b, c;
  logic [2:0] upd;

  int tests = 0;
  int fails = 0;
  int mon_n = 0;

  switch_debounce3 #(.DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .a    (a),
    .b    (b),
    .c    (c),
    .upd  (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel flips once its synchronised input has disagreed with the
  // current level on DB+1 consecutive edges (entry sample plus DB holds).
  bit [2:0] hist[$];
  bit [2:0] m_out;
  bit [2:0] m_upd;
  int       run[3];
  bit [5:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 3'b000;
      m_upd = 3'b000;
      for (int i = 0; i < 3; i++) run[i] = 0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(3'b000);
      exp_q.delete();
      exp_q.push_back(6'b0);
    end else begin
      bit [2:0] s;
      hist.push_back(sw_in);
      s = hist.pop_front();
      m_upd = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (s[i] != m_out[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == DB + 1) begin
          m_out[i] = ~m_out[i];
          m_upd[i] = 1'b1;
          run[i]   = 0;
        end
      end
      exp_q.push_back({m_out, m_upd});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      bit [5:0] e;
      e = exp_q.pop_front();
      mon_n++;
      check("scoreboard", {2'b00, c, b, a, upd}, {2'b00, e});
    end
  end

  // ---------------- stimulus helpers ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until the selected level reaches 1 (bounded at 20).
  task automatic edges_to_high(input int ch, output int k);
    logic [2:0] lv;
    k = 0;
    do begin
      step(1);
      k++;
      lv = {c, b, a};
    end while (!lv[ch] && k < 20);
  endtask

  int         k;
  logic [2:0] seen;

  initial begin
    rst_n = 1'b0;
    sw_in = 3'b111;
    step(3);
    check("reset_levels", {5'b0, c, b, a}, 8'h00);
    check("reset_upd", {5'b0, upd}, 8'h00);

    // Release with all inputs high: rise 6 edges after the first sampling edge.
    rst_n = 1'b1;
    edges_to_high(0, k);
    check("post_reset_latency", 8'(k), 8'd7);
    check("post_reset_all_high", {5'b0, c, b, a, 3'b0} >> 3, 8'h07);
    sw_in = 3'b000;
    step(12);

    // Single channel rise on a.
    sw_in = 3'b001;
    edges_to_high(0, k);
    check("a_rise_latency", 8'(k), 8'd7);
    check("a_rise_upd", {5'b0, upd}, 8'h01);
    step(1);
    check("a_upd_single_cycle", {5'b0, upd}, 8'h00);
    sw_in = 3'b000;
    step(12);

    // Short pulse on b never propagates.
    seen = 3'b000;
    sw_in = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen = seen | {upd[1], b, 1'b0};
    end
    sw_in = 3'b000;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen = seen | {upd[1], b, 1'b0};
    end
    check("b_short_pulse_rejected", {5'b0, seen}, 8'h00);

    // Bounce on c: 1,0,1,1,0 then held 1.
    sw_in = 3'b100; step(1);
    sw_in = 3'b000; step(1);
    sw_in = 3'b100; step(2);
    sw_in = 3'b000; step(1);
    sw_in = 3'b100;
    edges_to_high(2, k);
    check("c_bounce_latency", 8'(k), 8'd7);
    check("c_bounce_upd", {5'b0, upd}, 8'h04);
    step(1);
    check("c_upd_single_cycle", {5'b0, upd}, 8'h00);
    sw_in = 3'b000;
    step(12);

    // Simultaneous rise on all channels.
    sw_in = 3'b111;
    edges_to_high(0, k);
    check("all_rise_latency", 8'(k), 8'd7);
    check("all_rise_levels", {5'b0, c, b, a}, 8'h07);
    check("all_rise_upd", {5'b0, upd}, 8'h07);
    step(1);
    check("all_upd_single_cycle", {5'b0, upd}, 8'h00);

    // Drop a, reset two cycles into its falling wait window.
    sw_in = 3'b110;
    step(4);
    rst_n = 1'b0;
    #1;
    check("midwait_reset_a", {7'b0, a}, 8'h00);
    check("midwait_reset_upd", {5'b0, upd}, 8'h00);
    step(2);
    rst_n = 1'b1;
    step(12);
    check("after_reset_a_low", {7'b0, a}, 8'h00);
    check("after_reset_bc_high", {6'b0, c, b}, 8'h03);

    // Random segments of random length, mixing short bounces and long holds.
    for (int seg = 0; seg < 120; seg++) begin
      sw_in = 3'($urandom_range(0, 7));
      step($urandom_range(1, 9));
    end
    sw_in = 3'b000;
    step(12);

    check("scoreboard_active", 8'(mon_n > 500), 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
